// File: rtl/change_pkg.sv
// Shared types and constants for the change-payout controller.
package change_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECIDE,
    ISSUE_COIN,
    ISSUE_NOTE,
    DONE,
    FAIL
  } state_t;

  localparam logic DEN_COIN = 1'b0;
  localparam logic DEN_NOTE = 1'b1;

  localparam int DEF_COIN_VAL = 2;
  localparam int DEF_NOTE_VAL = 10;

endpackage

// File: rtl/inventory_counter.sv
// Stock counter for one denomination: decrement on payout, saturating refill.
module inventory_counter #(
  parameter int CNT_W = 6,
  parameter int INIT  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dec,
  input  logic             add,
  input  logic [CNT_W-1:0] qty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   sum;

  // One extra bit of headroom so count - dec + qty can be saturated after the fact.
  always_comb begin
    sum     = {1'b0, count_q} - {{CNT_W{1'b0}}, dec} + (add ? {1'b0, qty} : '0);
    count_d = (sum > MAX) ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= CNT_W'(INIT);
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout controller: notes first, then coins, over a req/ack handshake.
module change_dispenser
  import change_pkg::*;
#(
  parameter int AMOUNT_W   = 8,
  parameter int COIN_VAL   = DEF_COIN_VAL,
  parameter int NOTE_VAL   = DEF_NOTE_VAL,
  parameter int CNT_W      = 6,
  parameter int INIT_COINS = 20,
  parameter int INIT_NOTES = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [AMOUNT_W-1:0] amount,
  input  logic                disp_ack,
  input  logic                refill_coin,
  input  logic                refill_note,
  input  logic [CNT_W-1:0]    refill_qty,
  output logic                coin_req,
  output logic                note_req,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [AMOUNT_W-1:0] remaining,
  output logic [CNT_W-1:0]    coin_count,
  output logic [CNT_W-1:0]    note_count
);

  localparam logic [AMOUNT_W-1:0] COIN_AMT = AMOUNT_W'(COIN_VAL);
  localparam logic [AMOUNT_W-1:0] NOTE_AMT = AMOUNT_W'(NOTE_VAL);

  state_t              state_q, state_d;
  logic [AMOUNT_W-1:0] remaining_q, remaining_d;
  logic                coin_req_q, coin_req_d;
  logic                note_req_q, note_req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                coin_dec, note_dec;
  logic                den_sel;
  logic [AMOUNT_W-1:0] item_val;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_dec    = 1'b0;
    note_dec    = 1'b0;
    den_sel     = (state_q == ISSUE_NOTE) ? DEN_NOTE : DEN_COIN;
    item_val    = (den_sel == DEN_NOTE) ? NOTE_AMT : COIN_AMT;

    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = amount;
          state_d     = DECIDE;
        end
      end
      DECIDE: begin
        if (remaining_q == '0)                                  state_d = DONE;
        else if (remaining_q >= NOTE_AMT && note_count != '0)   state_d = ISSUE_NOTE;
        else if (remaining_q >= COIN_AMT && coin_count != '0)   state_d = ISSUE_COIN;
        else                                                    state_d = FAIL;
      end
      ISSUE_COIN, ISSUE_NOTE: begin
        if (disp_ack) begin
          remaining_d = remaining_q - item_val;
          coin_dec    = (den_sel == DEN_COIN);
          note_dec    = (den_sel == DEN_NOTE);
          state_d     = DECIDE;
        end
      end
      DONE, FAIL: state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    coin_req_d = (state_d == ISSUE_COIN);
    note_req_d = (state_d == ISSUE_NOTE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    error_d    = (state_d == FAIL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      coin_req_q  <= 1'b0;
      note_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_req_q  <= coin_req_d;
      note_req_q  <= note_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  inventory_counter #(.CNT_W(CNT_W), .INIT(INIT_COINS)) u_coins (
    .clock (clock),
    .reset (reset),
    .dec   (coin_dec),
    .add   (refill_coin),
    .qty   (refill_qty),
    .count (coin_count)
  );

  inventory_counter #(.CNT_W(CNT_W), .INIT(INIT_NOTES)) u_notes (
    .clock (clock),
    .reset (reset),
    .dec   (note_dec),
    .add   (refill_note),
    .qty   (refill_qty),
    .count (note_count)
  );

  assign coin_req  = coin_req_q;
  assign note_req  = note_req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected items and results queued, monitor compares.
module tb_change_dispenser;

  localparam int AMOUNT_W = 8;
  localparam int CNT_W    = 6;

  logic                clock = 1'b0;
  logic                reset;
  logic                start = 1'b0;
  logic [AMOUNT_W-1:0] amount = '0;
  logic                disp_ack = 1'b0;
  logic                refill_coin = 1'b0;
  logic                refill_note = 1'b0;
  logic [CNT_W-1:0]    refill_qty = '0;
  logic                coin_req, note_req, busy, done, error;
  logic [AMOUNT_W-1:0] remaining;
  logic [CNT_W-1:0]    coin_count, note_count;

  change_dispenser #(
    .AMOUNT_W(AMOUNT_W), .COIN_VAL(2), .NOTE_VAL(10),
    .CNT_W(CNT_W), .INIT_COINS(20), .INIT_NOTES(5)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .amount(amount),
    .disp_ack(disp_ack), .refill_coin(refill_coin), .refill_note(refill_note),
    .refill_qty(refill_qty), .coin_req(coin_req), .note_req(note_req),
    .busy(busy), .done(done), .error(error), .remaining(remaining),
    .coin_count(coin_count), .note_count(note_count)
  );

  always #5 clock = ~clock;

  typedef struct { bit note; int hold; } item_t;
  typedef struct { bit err; int rem; int cc; int nc; } res_t;

  item_t item_q[$];
  res_t  res_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    last_lat = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_items(input bit note, input int n, input int hold);
    item_t it;
    it.note = note;
    it.hold = hold;
    for (int i = 0; i < n; i++) item_q.push_back(it);
  endtask

  task automatic push_res(input bit err, input int rem, input int cc, input int nc);
    res_t r;
    r.err = err; r.rem = rem; r.cc = cc; r.nc = nc;
    res_q.push_back(r);
  endtask

  // Monitor: one item per req high-run, one result per done/error pulse.
  int run = 0;
  bit run_note = 1'b0;
  initial begin
    item_t it;
    res_t  r;
    forever begin
      @(negedge clock);
      if (reset) begin
        run = 0;
      end else begin
        if (coin_req || note_req) begin
          if (run == 0) begin
            run_note = note_req;
            chk("req_exclusive", int'(coin_req && note_req), 0);
          end
          run++;
        end else if (run > 0) begin
          if (item_q.size() == 0) begin
            chk("unexpected_item", 1, 0);
          end else begin
            it = item_q.pop_front();
            chk("item_den_note", int'(run_note), int'(it.note));
            chk("item_hold", run, it.hold);
          end
          run = 0;
        end
        if (done || error) begin
          if (res_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            r = res_q.pop_front();
            chk("error_pulse", int'(error), int'(r.err));
            chk("done_pulse", int'(done), int'(!r.err));
            chk("remaining", int'(remaining), r.rem);
            chk("coin_count", int'(coin_count), r.cc);
            chk("note_count", int'(note_count), r.nc);
          end
        end
      end
    end
  end

  task automatic pay(input int amt, input int dly, input int ref_idx, input int ref_qty);
    int waitc, guard, acks;
    amount = AMOUNT_W'(amt);
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waitc = 0; guard = 0; acks = 0;
    while (!(done || error) && guard < 400) begin
      refill_coin = 1'b0;
      if (disp_ack) begin
        disp_ack = 1'b0;
      end else if (coin_req || note_req) begin
        if (waitc == dly) begin
          disp_ack = 1'b1;
          waitc = 0;
          if (acks == ref_idx) begin
            refill_coin = 1'b1;
            refill_qty  = CNT_W'(ref_qty);
          end
          acks++;
        end else begin
          waitc++;
        end
      end
      @(negedge clock);
      guard++;
    end
    disp_ack = 1'b0;
    refill_coin = 1'b0;
    last_lat = guard;
    if (guard >= 400) chk("payout_timeout", guard, 0);
    @(negedge clock);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    #12 reset = 1'b0;
    @(negedge clock);
    chk("rst_coin_count", int'(coin_count), 20);
    chk("rst_note_count", int'(note_count), 5);
    chk("rst_busy", int'(busy), 0);
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_reqs", int'(coin_req | note_req | done | error), 0);

    // 28 = 2 notes + 4 coins
    push_items(1'b1, 2, 1); push_items(1'b0, 4, 1); push_res(1'b0, 0, 16, 3);
    pay(28, 0, -1, 0);

    // drain notes
    push_items(1'b1, 3, 1); push_res(1'b0, 0, 16, 0);
    pay(30, 0, -1, 0);

    // no notes: 16 paid in 8 coins
    push_items(1'b0, 8, 1); push_res(1'b0, 0, 8, 0);
    pay(16, 0, -1, 0);

    refill_note = 1'b1; refill_qty = 6'd5;
    @(negedge clock);
    refill_note = 1'b0;
    chk("refill_note", int'(note_count), 5);

    // 13: note, coin, then stuck with 1
    push_items(1'b1, 1, 1); push_items(1'b0, 1, 1); push_res(1'b1, 1, 7, 4);
    pay(13, 0, -1, 0);
    chk("remaining_held", int'(remaining), 1);

    // ack delayed 3 cycles: each req held 4 sampled cycles
    push_items(1'b1, 1, 4); push_items(1'b0, 1, 4); push_res(1'b0, 0, 6, 3);
    pay(12, 3, -1, 0);

    disp_ack = 1'b1;
    @(negedge clock); @(negedge clock);
    disp_ack = 1'b0;
    @(negedge clock);
    chk("stray_ack_coins", int'(coin_count), 6);
    chk("stray_ack_notes", int'(note_count), 3);
    chk("stray_ack_busy", int'(busy), 0);

    refill_coin = 1'b1; refill_qty = 6'd57;
    @(negedge clock);
    refill_coin = 1'b0;
    chk("refill_to_max", int'(coin_count), 63);

    // refill with ack at full stock: 63 - 1 + 5 saturates to 63
    push_items(1'b0, 1, 1); push_res(1'b0, 0, 63, 3);
    pay(2, 0, 0, 5);

    // reset mid note handshake
    amount = 8'd10; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    guard = 0;
    while (!note_req && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    chk("note_req_seen", int'(note_req), 1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_note_req", int'(note_req), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_coins", int'(coin_count), 20);
    chk("rst_mid_notes", int'(note_count), 5);
    @(negedge clock); @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);

    push_items(1'b0, 4, 1); push_res(1'b0, 0, 16, 5);
    pay(8, 0, -1, 0);
    push_items(1'b0, 4, 1); push_res(1'b0, 0, 12, 5);
    pay(8, 0, -1, 0);
    // third ack at count 10 with refill 5 -> 14
    push_items(1'b0, 3, 1); push_res(1'b0, 0, 14, 5);
    pay(6, 0, 2, 5);

    push_res(1'b0, 0, 14, 5);
    pay(0, 0, -1, 0);
    chk("zero_amount_latency", last_lat, 1);

    @(negedge clock); @(negedge clock);
    chk("items_left", item_q.size(), 0);
    chk("results_left", res_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
